// File: rtl/add_arbiter.sv
// Purpose: round-robin arbiter sharing one N-bit ripple adder between two requesters.
// Latency: operands accepted in cycle T give rsp_valid in cycle T+2; one op per 3 cycles at best.
// Backpressure: result holds in RESP until rsp_ready; requests wait (not dropped) while busy.
module add_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [N:0]   rsp_sum,
    input  logic         rsp_ready,
    output logic         busy,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation latched at grant time; the adder works only from this copy
    typedef struct packed {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } op_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;        // requester that wins when both are valid
    op_t    op_q;
    op_t    op_nxt;
    logic   grant_any;
    logic   grant_id;
    logic   carry;
    logic [N:0] sum_full;

    // Next-state, grant and ready generation; readies are only ever raised in IDLE
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        op_nxt     = op_q;
        unique case (state)
            IDLE: begin
                // rst gating keeps both readies low for the whole reset window
                if (!rst && (req0_valid || req1_valid)) begin
                    grant_any  = 1'b1;
                    grant_id   = req1_valid && (!req0_valid || ptr);
                    req0_ready = !grant_id;
                    req1_ready = grant_id;
                    op_nxt.id  = grant_id;
                    op_nxt.a   = grant_id ? req1_a : req0_a;
                    op_nxt.b   = grant_id ? req1_b : req0_b;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shared ripple-carry adder, carry-in tied to zero, full N+1-bit result
    always_comb begin
        carry    = 1'b0;
        sum_full = '0;
        for (int i = 0; i < N; i++) begin
            sum_full[i] = op_q.a[i] ^ op_q.b[i] ^ carry;
            carry       = (op_q.a[i] & op_q.b[i]) | (carry & (op_q.a[i] ^ op_q.b[i]));
        end
        sum_full[N] = carry;
    end

    // Operand latch, round-robin pointer, response registers and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            op_count  <= 8'd0;
        end else begin
            if (grant_any) begin
                op_q <= op_nxt;
                ptr  <= ~grant_id;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_q.id;
                rsp_sum   <= sum_full;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Purpose: scoreboard bench for add_arbiter (N=4) with directed and swept traffic.
// Latency: driver pushes expectations at grant; monitor pops on each rsp handshake.
// Backpressure: rsp_ready is driven directed or random to exercise the RESP hold.
module tb_add_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic       id;
        logic [N:0] sum;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic [N:0]   rsp_sum;
    logic         rsp_ready;
    logic         busy;
    logic [7:0]   op_count;

    int   checks;
    int   errors;
    int   done_cnt;
    exp_t exp_q[$];

    add_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol invariants, RESP stability and scoreboard pop on each handshake
    logic       prev_hold;
    logic       p_id;
    logic [N:0] p_sum;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL ready_exclusive: got both ready required at most one at %0t", $time);
            end
            checks++;
            if (busy && (req0_ready || req1_ready)) begin
                errors++;
                $display("FAIL ready_when_busy: got ready=%b%b required 00 at %0t", req1_ready, req0_ready, $time);
            end
            if (prev_hold) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== p_id || rsp_sum !== p_sum) begin
                    errors++;
                    $display("FAIL rsp_stable: got v=%b id=%b sum=%h required v=1 id=%b sum=%h at %0t",
                             rsp_valid, rsp_id, rsp_sum, p_id, p_sum, $time);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%b sum=%h required no response at %0t", rsp_id, rsp_sum, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                        errors++;
                        $display("FAIL rsp_data: got id=%b sum=%h required id=%b sum=%h at %0t",
                                 rsp_id, rsp_sum, e.id, e.sum, $time);
                    end
                end
                done_cnt++;
            end
            prev_hold = rsp_valid && !rsp_ready;
            p_id      = rsp_id;
            p_sum     = rsp_sum;
        end
    end

    task automatic push_exp(input logic id, input logic [N:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Leaves the bench at posedge+1 with rst just released and all inputs idle
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Streams `total` operations with random operands; expectations come from a+b in N+1 bits
    task automatic run_ops(input int total, input bit use1, input bit rnd);
        int   issued = 0;
        int   budget = 0;
        int   start  = done_cnt;
        logic acc0   = 1'b0;
        logic acc1   = 1'b0;
        while ((done_cnt - start) < total && budget < total * 16 + 50) begin
            @(posedge clk);
            #1;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!req0_valid && (issued + int'(req1_valid)) < total) begin
                req0_a     = 4'($urandom_range(0, 15));
                req0_b     = 4'($urandom_range(0, 15));
                req0_valid = 1'b1;
            end
            if (use1 && !req1_valid && (issued + int'(req0_valid)) < total) begin
                req1_a     = 4'($urandom_range(0, 15));
                req1_b     = 4'($urandom_range(0, 15));
                req1_valid = 1'b1;
            end
            @(negedge clk);
            if (req0_ready) begin
                push_exp(1'b0, {1'b0, req0_a} + {1'b0, req0_b});
                issued++;
                acc0 = 1'b1;
            end
            if (req1_ready) begin
                push_exp(1'b1, {1'b0, req1_a} + {1'b0, req1_b});
                issued++;
                acc1 = 1'b1;
            end
            budget++;
        end
        chk("run_ops_done", done_cnt - start, total);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
    endtask

    int gid[8];
    int gcyc[8];
    int ng;

    initial begin
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 4'hF;
        req0_b     = 4'h1;
        req1_valid = 1'b0;
        req1_a     = 4'h0;
        req1_b     = 4'h0;
        rsp_ready  = 1'b0;

        // Reset state, with a request already pending
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_busy", busy, 0);

        // F+1 on requester 0: grant at T, result 5'h10 at T+2, then held without rsp_ready
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t0_req0_ready", req0_ready, 1);
        chk("t0_req1_ready", req1_ready, 0);
        push_exp(1'b0, 5'h10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 4'h6;
        req1_b     = 4'h7;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_sum", rsp_sum, 5'h10);
        chk("t2_rsp_id", rsp_id, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_req1_ready", req1_ready, 0);
            chk("hold_op_count", op_count, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pulse_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("after_op_count", op_count, 1);
        chk("after_rsp_valid", rsp_valid, 0);
        chk("waiting_req1_ready", req1_ready, 1);
        push_exp(1'b1, 5'h0D);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        wait_drain();

        // Both requesters valid continuously: grants 0,1,0,1 three cycles apart
        do_reset();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 4'h3;
        req0_b     = 4'h5;
        req1_valid = 1'b1;
        req1_a     = 4'hA;
        req1_b     = 4'h9;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && ng < 8) begin
                gid[ng]  = req1_ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
                if (req1_ready) push_exp(1'b1, 5'h13);
                else            push_exp(1'b0, 5'h08);
            end
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_op_count", op_count, 4);
        chk("rr_grants", ng, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant_id", gid[k], k % 2);
            chk("rr_grant_cycle", gcyc[k], 3 * k);
        end

        // Reset during EXEC discards the op; next request still sees T+2 latency
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_a     = 4'h7;
        req0_b     = 4'h8;
        @(negedge clk);
        chk("ex_req0_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("ex_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("ex_rst_rsp_valid", rsp_valid, 0);
        chk("ex_rst_op_count", op_count, 0);
        chk("ex_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 4'h2;
        req1_b     = 4'h3;
        @(negedge clk);
        chk("ex_req1_ready", req1_ready, 1);
        push_exp(1'b1, 5'h05);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("ex_t1_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("ex_t2_rsp_valid", rsp_valid, 1);
        chk("ex_t2_rsp_sum", rsp_sum, 5'h05);
        wait_drain();

        // op_count wrap after 256 completions
        do_reset();
        run_ops(255, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_255", op_count, 255);
        run_ops(1, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_wrap", op_count, 0);

        // Random operands on both requesters with random backpressure
        run_ops(40, 1'b1, 1'b1);
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: N, default 4, operand width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an add pending.
REQ-005 Port: req0_a, req0_b  input  N each  requester 0 operands.
REQ-006 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same as REQ-004 to REQ-006, for requester 1.
REQ-008 Port: rsp_valid  output  1  result available.
REQ-009 Port: rsp_id  output  1  requester that owns the current result.
REQ-010 Port: rsp_sum  output  N+1  result {carry, sum}.
REQ-011 Port: rsp_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: busy  output  1  high in EXEC or RESP.
REQ-013 Port: op_count  output  8  completed-operation counter.

Function
REQ-014 The block SHALL share exactly one N-bit ripple adder, carry-in 0, output N+1 bits, between the two requesters.
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE with at least one valid request, the block SHALL grant one requester, assert only that requester's ready combinationally in the same cycle, latch its operands and id, and go to EXEC.
REQ-017 Arbitration SHALL be round-robin via a 1-bit priority pointer.
  - Both requesters valid: grant the one the pointer selects.
  - One requester valid: grant it, regardless of the pointer.
REQ-018 After each grant, the pointer SHALL point to the requester that was not granted.
REQ-019 In EXEC, the block SHALL register the adder output into rsp_sum, set rsp_valid=1, and go to RESP.
REQ-020 In RESP, rsp_valid, rsp_id and rsp_sum SHALL hold stable until a cycle with rsp_ready=1.
  - On that cycle: clear rsp_valid, increment op_count, go to IDLE.
REQ-021 Latency: operands accepted in cycle T SHALL give rsp_valid=1 in cycle T+2.
  - Minimum issue interval: 3 cycles.
  - rsp_ready held high: one op every 3 cycles.
REQ-022 Both ready outputs SHALL be 0 outside IDLE, and never 1 at the same time.
REQ-023 Requests arriving in EXEC or RESP SHALL be neither accepted nor dropped.
  - They are arbitered on the first IDLE cycle.
  - Requesters hold valid and operands until ready.
REQ-024 rsp_ready in IDLE or EXEC SHALL have no effect.
REQ-025 Arithmetic SHALL be unsigned: rsp_sum = req_a + req_b, full N+1 bits, no truncation.
REQ-026 op_count SHALL wrap from 255 to 0.
REQ-027 A requester deasserting valid without ready SHALL leave the FSM and pointer unchanged.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL force:
  - state IDLE;
  - pointer to requester 0;
  - rsp_valid=0, rsp_id=0, rsp_sum=0;
  - op_count=0, busy=0;
  - both ready outputs 0.
REQ-029 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without incrementing op_count.
REQ-030 On the first clock edge after rst falls, the block SHALL arbitrate normally.

Verification
REQ-031 N=4, only req0 valid with a=4'hF, b=4'h1 at cycle T → req0_ready=1 at T; rsp_valid=1, rsp_sum=5'h10, rsp_id=0 at T+2.
REQ-032 Both valid continuously, rsp_ready=1, after reset → grants alternate 0,1,0,1; one response every 3 cycles; op_count=4 after 12 cycles.
REQ-033 rsp_ready held 0 for 5 cycles in RESP → rsp_valid, rsp_id, rsp_sum stable; no ready asserted; op_count unchanged until the rsp_ready pulse.
REQ-034 rst pulsed mid-EXEC → rsp_valid=0, op_count=0, busy=0 immediately; next request is served with T+2 latency.
REQ-035 256 completed operations → op_count=0.
REQ-036 Random a/b sweep, both requesters, random rsp_ready → every rsp_sum = a+b of the matching rsp_id; no lost or duplicated operations.
